booth_mul_sched: RTL

Operand scheduler and result collector placed directly upstream of the sequential Booth radix-4 multiplier. It accepts tagged operand pairs over a valid/ready interface and buffers them in a small FIFO. It presents one pair at a time to the multiplier with `mul_vld` held high and operands held stable until `mul_done`. Each product is returned with its tag and an error flag through a single-entry valid/ready output register, and a watchdog aborts any multiply that never completes.

---
 rtl/booth_mul_sched_if.sv | 42 ++++
 rtl/booth_mul_sched.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_sched_if.sv
// Handshake bundle for booth_mul_sched: operand input, multiplier request/response
// and result output channels.
//   slave  : the scheduler (accepts operands, drives the multiplier, returns results)
//   master : the environment (operand source, multiplier, result consumer)
interface booth_mul_sched_if #(
   parameter int unsigned WIDTH_M = 8,
   parameter int unsigned WIDTH_R = 8,
   parameter int unsigned TAG_W   = 4
);
   localparam int unsigned PROD_W = WIDTH_M + WIDTH_R;

   // operand input channel
   logic               in_vld;
   logic               in_rdy;
   logic [WIDTH_M-1:0] in_m;
   logic [WIDTH_R-1:0] in_r;
   logic [TAG_W-1:0]   in_tag;

   // multiplier request/response
   logic               mul_vld;
   logic [WIDTH_M-1:0] mul_m;
   logic [WIDTH_R-1:0] mul_r;
   logic [PROD_W-1:0]  mul_prod;
   logic               mul_done;

   // result output channel
   logic               out_vld;
   logic               out_rdy;
   logic [PROD_W-1:0]  out_prod;
   logic [TAG_W-1:0]   out_tag;
   logic               out_err;

   modport slave (
      input  in_vld, in_m, in_r, in_tag, mul_prod, mul_done, out_rdy,
      output in_rdy, mul_vld, mul_m, mul_r, out_vld, out_prod, out_tag, out_err
   );

   modport master (
      output in_vld, in_m, in_r, in_tag, mul_prod, mul_done, out_rdy,
      input  in_rdy, mul_vld, mul_m, mul_r, out_vld, out_prod, out_tag, out_err
   );
endinterface

// File: rtl/booth_mul_sched.sv
// Operand scheduler / result collector in front of a sequential Booth multiplier.
// Buffers tagged operand pairs in a FIFO, issues one at a time with a level-held
// request, collects the product (or a watchdog abort) into a single output register.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : booth_mul_sched_if.slave (operand in, multiplier req/resp, result out)
//   busy : FIFO non-empty or FSM not idle
module booth_mul_sched #(
   parameter int unsigned WIDTH_M = 8,
   parameter int unsigned WIDTH_R = 8,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   booth_mul_sched_if.slave  bus,
   output logic              busy
);
   localparam int unsigned PROD_W = WIDTH_M + WIDTH_R;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned WDOG_W = $clog2(TIMEOUT);

   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [WIDTH_R-1:0] r;
      logic [WIDTH_M-1:0] m;
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_t;

   op_t               mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   op_t               head;
   logic              in_rdy;
   logic              push;
   logic              pop;
   logic              fifo_empty;

   state_t            state;
   state_t            state_nxt;
   logic [WDOG_W-1:0] wdog;
   logic [WDOG_W-1:0] wdog_nxt;
   logic              load_res;
   logic              res_err;
   logic [PROD_W-1:0] res_prod;

   logic               mul_vld_q;
   logic [WIDTH_M-1:0] mul_m_q;
   logic [WIDTH_R-1:0] mul_r_q;
   logic               out_vld_q;
   logic [PROD_W-1:0]  out_prod_q;
   logic [TAG_W-1:0]   out_tag_q;
   logic               out_err_q;

   // FIFO status; in_rdy is gated by rst so nothing is accepted during reset
   assign fifo_empty = (count == '0);
   assign in_rdy     = (count < CNT_W'(DEPTH)) && !rst;
   assign push       = bus.in_vld && in_rdy;
   assign head       = mem[rd_ptr];

   // FIFO storage (no reset needed; validity is tracked by count)
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{tag: bus.in_tag, r: bus.in_r, m: bus.in_m};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FSM state and watchdog registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wdog  <= '0;
      end else begin
         state <= state_nxt;
         wdog  <= wdog_nxt;
      end
   end

   // FSM next state; mul_done wins over a coincident watchdog expiry
   always_comb begin
      state_nxt = state;
      wdog_nxt  = '0;
      pop       = 1'b0;
      load_res  = 1'b0;
      res_err   = 1'b0;
      res_prod  = '0;
      case (state)
         IDLE: begin
            if (!fifo_empty && !out_vld_q) state_nxt = ISSUE;
         end
         ISSUE: begin
            wdog_nxt = wdog + WDOG_W'(1);
            if (bus.mul_done) begin
               pop       = 1'b1;
               load_res  = 1'b1;
               res_prod  = bus.mul_prod;
               state_nxt = GAP;
            end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
               pop       = 1'b1;
               load_res  = 1'b1;
               res_err   = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Multiplier request: operands latched on entry to ISSUE and held for the whole state
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_vld_q <= 1'b0;
         mul_m_q   <= '0;
         mul_r_q   <= '0;
      end else begin
         mul_vld_q <= (state_nxt == ISSUE);
         if (state == IDLE && state_nxt == ISSUE) begin
            mul_m_q <= head.m;
            mul_r_q <= head.r;
         end
      end
   end

   // Single-entry result register; issue is blocked while it is full
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q  <= 1'b0;
         out_prod_q <= '0;
         out_tag_q  <= '0;
         out_err_q  <= 1'b0;
      end else if (load_res) begin
         out_vld_q  <= 1'b1;
         out_prod_q <= res_prod;
         out_tag_q  <= head.tag;
         out_err_q  <= res_err;
      end else if (bus.out_rdy) begin
         out_vld_q  <= 1'b0;
      end
   end

   assign bus.in_rdy   = in_rdy;
   assign bus.mul_vld  = mul_vld_q;
   assign bus.mul_m    = mul_m_q;
   assign bus.mul_r    = mul_r_q;
   assign bus.out_vld  = out_vld_q;
   assign bus.out_prod = out_prod_q;
   assign bus.out_tag  = out_tag_q;
   assign bus.out_err  = out_err_q;
   assign busy         = !fifo_empty || (state != IDLE);

endmodule
